button_debouncer: RTL and testbench

//   Per-channel synchronizer and debouncer for raw board push buttons.

---
 rtl/button_debouncer.sv | 121 ++++++++++++
 tb/tb_button_debouncer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Per-channel two-flop synchronizer and debouncer for raw board
//               push buttons. The debounced level feeds a PIO in_port so that
//               edge capture sees exactly one clean rising edge per press.
//               One-cycle press/release pulses are also provided.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH       number of button channels
//   DEBOUNCE_N  consecutive stable synced cycles required before the output
//               follows (must be >= 2)
//   ACTIVE_LOW  1: raw pin reads 0 when pressed; 0: raw pin reads 1 when pressed
//   CNT_W       counter width, 2**CNT_W >= DEBOUNCE_N
// Ports
//   clk            in   1      system clock
//   reset_n        in   1      asynchronous reset, active-low
//   raw_in         in   WIDTH  asynchronous button pins
//   bypass         in   1      1: output follows the synchronized level
//   button_out     out  WIDTH  debounced level, 1 = pressed
//   press_pulse    out  WIDTH  1-cycle pulse when button_out[i] rises
//   release_pulse  out  WIDTH  1-cycle pulse when button_out[i] falls
//   busy           out  1      any channel counter nonzero
// ============================================================================
module button_debouncer #(
    parameter int WIDTH      = 4,
    parameter int DEBOUNCE_N = 500000,
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_W      = 19
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             bypass,
    output logic [WIDTH-1:0] button_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic             busy
);

    // Terminal count: the DEBOUNCE_N-th consecutive mismatch cycle commits.
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_N - 1);

    logic [WIDTH-1:0] w_lvl;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] w_btn_nxt;
    logic [WIDTH-1:0] w_cnt_nz_nxt;

    // Normalize so that 1 always means "pressed".
    assign w_lvl = (ACTIVE_LOW != 0) ? ~raw_in : raw_in;

    // Two-flop synchronizer; nothing downstream looks at raw_in or r_s1
    // other than r_s2, keeping the metastability window to the first stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_lvl;
            r_s2 <= r_s1;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic             w_btn_nxt_ch;

            // The count only advances while the synced level disagrees with
            // the committed output; any agreeing cycle restarts it, so a
            // glitch shorter than DEBOUNCE_N never reaches the output. The
            // counter stops at c_cnt_max and clears on the committing edge,
            // so it can never wrap.
            always_comb begin
                w_cnt_nxt    = '0;
                w_btn_nxt_ch = button_out[i];
                if (bypass) begin
                    w_btn_nxt_ch = r_s2[i];
                end else if (r_s2[i] != button_out[i]) begin
                    if (r_cnt == c_cnt_max) begin
                        w_btn_nxt_ch = r_s2[i];
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_nxt;
                end
            end

            assign w_btn_nxt[i]    = w_btn_nxt_ch;
            assign w_cnt_nz_nxt[i] = |w_cnt_nxt;
        end
    endgenerate

    // Pulses are derived from the next output value so that each pulse is
    // coincident with the first cycle of the new button_out level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            button_out    <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            busy          <= 1'b0;
        end else begin
            button_out    <= w_btn_nxt;
            press_pulse   <= w_btn_nxt & ~button_out;
            release_pulse <= ~w_btn_nxt & button_out;
            busy          <= |w_cnt_nz_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench for button_debouncer (WIDTH=4,
//               DEBOUNCE_N=8, ACTIVE_LOW=1). A window-based reference model
//               predicts every output each cycle; directed tables and
//               hand-written sequences cover the latency and glitch corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int WIDTH = 4;
    localparam int N     = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             bypass;
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] button_out;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    button_debouncer #(
        .WIDTH      (WIDTH),
        .DEBOUNCE_N (N),
        .ACTIVE_LOW (1),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .raw_in        (raw_in),
        .bypass        (bypass),
        .button_out    (button_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the output of a channel flips when the last N
    // non-bypass edges all saw a synced level different from the output.
    // The synced level seen at an edge is the pressed level sampled two
    // edges earlier (0 if fewer samples exist since reset).
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] m_out, m_press, m_rel;
    logic             m_busy;
    logic [N-1:0]     m_win [WIDTH];
    logic [WIDTH-1:0] m_hist [$];

    task automatic model_reset();
        m_out   = '0;
        m_press = '0;
        m_rel   = '0;
        m_busy  = 1'b0;
        m_hist.delete();
        for (int c = 0; c < WIDTH; c++) m_win[c] = '0;
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] s2;
        logic [WIDTH-1:0] nxt;
        logic             b;
        s2 = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : '0;
        b  = 1'b0;
        for (int c = 0; c < WIDTH; c++) begin
            nxt[c] = m_out[c];
            if (bypass) begin
                nxt[c]   = s2[c];
                m_win[c] = '0;
            end else begin
                m_win[c] = {m_win[c][N-2:0], (s2[c] != m_out[c])};
                if (m_win[c] == '1) begin
                    nxt[c]   = s2[c];
                    m_win[c] = '0;
                end else if (s2[c] != m_out[c]) begin
                    b = 1'b1;
                end
            end
        end
        m_press = nxt & ~m_out;
        m_rel   = ~nxt & m_out;
        m_out   = nxt;
        m_busy  = b;
        m_hist.push_back(~raw_in);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("model_button_out", 32'(button_out), 32'(m_out));
        chk("model_press", 32'(press_pulse), 32'(m_press));
        chk("model_release", 32'(release_pulse), 32'(m_rel));
        chk("model_busy", 32'(busy), 32'(m_busy));
    endtask

    // One clock: model advances on the active edge, outputs compared on the
    // falling edge; callers change inputs only at falling-edge time.
    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        compare_model();
    endtask

    // Asynchronous reset pulse in the middle of the low phase; outputs must
    // clear before any clock edge arrives.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_button_out", 32'(button_out), 32'h0);
        chk("rst_press", 32'(press_pulse), 32'h0);
        chk("rst_release", 32'(release_pulse), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] raw;
        logic       byp;
        int         n;
        logic [3:0] out;
        logic [3:0] press;
        logic [3:0] rel;
        logic       busy;
    } vec_t;

    vec_t tbl [$];

    initial begin
        int e, presses, rels, edge_at;
        bit pressed;
        int seg_lvl [5];
        int seg_len [5];

        // Clean press/release on ch0, then a 2-cycle ch3 glitch with and
        // without bypass. Expected values apply after the last edge of a row.
        tbl.push_back('{4'hE, 1'b0, 9, 4'h0, 4'h0, 4'h0, 1'b1});
        tbl.push_back('{4'hE, 1'b0, 1, 4'h1, 4'h1, 4'h0, 1'b0});
        tbl.push_back('{4'hE, 1'b0, 1, 4'h1, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'hE, 1'b0, 5, 4'h1, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'hF, 1'b0, 9, 4'h1, 4'h0, 4'h0, 1'b1});
        tbl.push_back('{4'hF, 1'b0, 1, 4'h0, 4'h0, 4'h1, 1'b0});
        tbl.push_back('{4'hF, 1'b0, 1, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'h7, 1'b1, 2, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'hF, 1'b1, 1, 4'h8, 4'h8, 4'h0, 1'b0});
        tbl.push_back('{4'hF, 1'b1, 1, 4'h8, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'hF, 1'b1, 1, 4'h0, 4'h0, 4'h8, 1'b0});
        tbl.push_back('{4'hF, 1'b1, 2, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'h7, 1'b0, 2, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'hF, 1'b0, 12, 4'h0, 4'h0, 4'h0, 1'b0});

        reset_n = 1'b0;
        raw_in  = 4'hF;
        bypass  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset with buttons released, then the directed table.
        do_reset();
        for (int r = 0; r < tbl.size(); r++) begin
            raw_in = tbl[r].raw;
            bypass = tbl[r].byp;
            repeat (tbl[r].n) step();
            chk($sformatf("tbl%0d_out", r), 32'(button_out), 32'(tbl[r].out));
            chk($sformatf("tbl%0d_press", r), 32'(press_pulse), 32'(tbl[r].press));
            chk($sformatf("tbl%0d_release", r), 32'(release_pulse), 32'(tbl[r].rel));
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
        end
        bypass = 1'b0;

        // Bounce on ch1: the 7-cycle low run falls one short of committing.
        raw_in = 4'hF;
        do_reset();
        seg_lvl = '{1, 0, 1, 0, 1};
        seg_len = '{5, 3, 7, 1, 24};
        e = 0; presses = 0; rels = 0; edge_at = -1;
        for (int s = 0; s < 5; s++) begin
            pressed = (seg_lvl[s] != 0);
            raw_in  = pressed ? 4'hD : 4'hF;
            for (int k = 0; k < seg_len[s]; k++) begin
                step();
                e++;
                if (press_pulse[1]) begin
                    presses++;
                    edge_at = e;
                end
                if (release_pulse[1]) rels++;
            end
        end
        chk("bounce_press_count", 32'(presses), 32'd1);
        chk("bounce_press_edge", 32'(edge_at), 32'd26);
        chk("bounce_release_count", 32'(rels), 32'd0);

        // Parallel presses: ch2/ch3 together, ch0 three cycles later.
        raw_in = 4'hF;
        do_reset();
        raw_in = 4'b0011;
        for (e = 1; e <= 14; e++) begin
            step();
            if (e == 3) raw_in = 4'b0010;
            if (e == 10) chk("parallel_press_a", 32'(press_pulse), 32'hC);
            if (e == 13) chk("parallel_press_b", 32'(press_pulse), 32'h1);
        end

        // Reset mid-count discards the partial count.
        raw_in = 4'hF;
        do_reset();
        raw_in = 4'hE;
        repeat (7) step();
        chk("midcount_busy", 32'(busy), 32'h1);
        do_reset();
        for (e = 1; e <= 10; e++) begin
            step();
            if (e == 9) chk("midcount_not_early", 32'(button_out), 32'h0);
            if (e == 10) chk("midcount_rise", 32'(button_out), 32'h1);
        end

        // Randomized traffic against the model.
        raw_in = 4'hF;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            raw_in = 4'($urandom);
            if ($urandom_range(0, 9) == 0) bypass = ~bypass;
            if ($urandom_range(0, 49) == 0) do_reset();
            repeat ($urandom_range(1, 14)) step();
        end
        bypass = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
